// File: rtl/divider_pkg.sv
// Shared constants and types for the sequential signed divider.
//   DW / VW      : dividend width and divisor/quotient/remainder width
//   CNT_W        : iteration counter width (DW iterations)
//   Q_MAX/Q_MIN  : quotient saturation values
//   state_t      : control FSM states
package divider_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned VW    = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [VW-1:0] Q_MAX = 8'h7F;
  localparam logic [VW-1:0] Q_MIN = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
//   i_rem     : partial remainder before the step (always < |D|)
//   i_n_bit   : next dividend magnitude bit, MSB first
//   i_d_mag   : divisor magnitude (0..128)
//   o_rem     : partial remainder after the step
//   o_q_bit   : quotient bit produced by the step
module div_restore_step
  import divider_pkg::*;
(
  input  logic [VW:0]   i_rem,
  input  logic          i_n_bit,
  input  logic [VW-1:0] i_d_mag,
  output logic [VW:0]   o_rem,
  output logic          o_q_bit
);

  localparam int unsigned TW = VW + 2;

  // One spare bit keeps the compare exact even if i_rem[VW] were ever set.
  logic [TW-1:0] w_trial;
  logic [TW-1:0] w_d_ext;

  assign w_trial = {i_rem, i_n_bit};
  assign w_d_ext = TW'(i_d_mag);

  assign o_q_bit = (w_trial >= w_d_ext);
  assign o_rem   = o_q_bit ? (VW+1)'(w_trial - w_d_ext) : (VW+1)'(w_trial);

endmodule

// File: rtl/signed_divider_seq.sv
// Iterative signed divider (16-bit / 8-bit), truncating toward zero, with
// fixed 17-cycle latency, quotient saturation and divide-by-zero flag.
//   clk, rst   : clock and asynchronous active-high reset
//   en         : start request, sampled only while idle
//   N, D       : signed dividend / divisor, captured on the accepting edge
//   Q, R       : signed quotient / remainder, held until the next result
//   busy       : job in flight
//   valid      : one-cycle result strobe
//   ovf, dbz   : quotient overflow / divide by zero, qualified by valid
module signed_divider_seq
  import divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] N,
  input  logic [VW-1:0] D,
  output logic [VW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          busy,
  output logic          valid,
  output logic          ovf,
  output logic          dbz
);

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_n_mag;
  logic [DW-1:0]    r_q_mag;
  logic [VW-1:0]    r_d_mag;
  logic [VW-1:0]    r_n_low;
  logic [VW:0]      r_rem;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz;

  logic [DW-1:0]    w_n_mag;
  logic [VW-1:0]    w_d_mag;
  logic [VW:0]      w_rem_next;
  logic             w_q_bit;
  logic             w_q_big;
  logic [VW-1:0]    w_q_fix;
  logic [VW-1:0]    w_r_fix;
  logic             w_ovf_fix;

  // Two's-complement magnitudes; the most negative inputs map to 2^(W-1).
  assign w_n_mag = N[DW-1] ? (~N + DW'(1)) : N;
  assign w_d_mag = D[VW-1] ? (~D + VW'(1)) : D;

  div_restore_step u_step (
    .i_rem   (r_rem),
    .i_n_bit (r_n_mag[DW-1]),
    .i_d_mag (r_d_mag),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  // Negative quotients may reach 128 before saturating, positive ones 127.
  assign w_q_big = r_sign_q ? (r_q_mag > DW'(128)) : (r_q_mag > DW'(127));

  // Sign fix-up, saturation and divide-by-zero substitution.
  always_comb begin
    w_q_fix   = r_sign_q ? (~r_q_mag[VW-1:0] + VW'(1)) : r_q_mag[VW-1:0];
    w_r_fix   = r_sign_r ? (~r_rem[VW-1:0] + VW'(1)) : r_rem[VW-1:0];
    w_ovf_fix = 1'b0;
    if (r_dbz) begin
      w_q_fix = r_sign_r ? Q_MIN : Q_MAX;
      w_r_fix = r_n_low;
    end else if (w_q_big) begin
      w_q_fix   = r_sign_q ? Q_MIN : Q_MAX;
      w_ovf_fix = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (en) w_next_state = CALC;
      CALC:    if (r_cnt == CNT_W'(DW - 1)) w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_n_mag  <= '0;
      r_q_mag  <= '0;
      r_d_mag  <= '0;
      r_n_low  <= '0;
      r_rem    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dbz    <= 1'b0;
      Q        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_sign_q <= N[DW-1] ^ D[VW-1];
            r_sign_r <= N[DW-1];
            r_n_mag  <= w_n_mag;
            r_d_mag  <= w_d_mag;
            r_n_low  <= N[VW-1:0];
            r_dbz    <= (D == '0);
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q_mag  <= '0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          r_rem   <= w_rem_next;
          r_q_mag <= {r_q_mag[DW-2:0], w_q_bit};
          r_n_mag <= {r_n_mag[DW-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          Q     <= w_q_fix;
          R     <= w_r_fix;
          ovf   <= w_ovf_fix;
          dbz   <= r_dbz;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
